mem_access_stage: RTL and testbench

Memory-access stage directly upstream of the commit stage.
- Accepts one instruction at a time from execute and performs its load or store on a simple req/resp data-memory port.
- Produces the registered integer-writeback, exception and difftest signals that the commit stage consumes.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: runs one load/store over a req/resp port and registers commit/writeback/exception outputs.
// Optional MEM_ACCESS_PERF_EN adds perf_loads, perf_stores and perf_stall_cycles counters.
module mem_access_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] MEM_BASE = 64'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_rd_wen,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [1:0]      in_mem_op,
  input  logic [1:0]      in_mem_size,
  input  logic            in_mem_unsigned,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            wb_valid,
  output logic [4:0]      wb_dest_addr,
  output logic [XLEN-1:0] wb_dest_data,
  output logic            commit,
  output logic            except_valid,
  output logic [5:0]      except_code,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_peripheral
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [63:0]     perf_loads,
  output logic [63:0]     perf_stores,
  output logic [63:0]     perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  state_t state, state_next;

  logic [XLEN-1:0] pc_q, result_q, store_data_q;
  logic [31:0]     inst_q;
  logic            rd_wen_q, unsigned_q;
  logic [4:0]      rd_addr_q;
  logic [1:0]      mem_op_q, mem_size_q;

  logic            accept, in_is_mem, in_misaligned;
  logic [7:0]      byte_en;
  logic [XLEN-1:0] resp_shifted, load_data;

  logic            nxt_commit, nxt_wb_valid, nxt_except, nxt_periph;
  logic [5:0]      nxt_code;
  logic [4:0]      nxt_rd;
  logic [XLEN-1:0] nxt_data, nxt_pc;
  logic [31:0]     nxt_inst;

  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      2'd2:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

  assign in_ready      = (state == IDLE);
  assign accept        = in_valid && in_ready;
  assign in_is_mem     = (in_mem_op == OP_LOAD) || (in_mem_op == OP_STORE);
  assign in_misaligned = in_is_mem && misaligned(in_result[2:0], in_mem_size);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (in_is_mem && !in_misaligned) ? REQ : DONE;
      REQ:     if (mem_req_ready) state_next = RESP;
      RESP:    if (mem_resp_valid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= '0;
      inst_q       <= '0;
      rd_wen_q     <= 1'b0;
      rd_addr_q    <= '0;
      result_q     <= '0;
      store_data_q <= '0;
      mem_op_q     <= '0;
      mem_size_q   <= '0;
      unsigned_q   <= 1'b0;
    end else if (accept) begin
      pc_q         <= in_pc;
      inst_q       <= in_inst;
      rd_wen_q     <= in_rd_wen;
      rd_addr_q    <= in_rd_addr;
      result_q     <= in_result;
      store_data_q <= in_store_data;
      mem_op_q     <= in_mem_op;
      mem_size_q   <= in_mem_size;
      unsigned_q   <= in_mem_unsigned;
    end
  end

  // Request fields come only from captured state, so they stay put through a stall.
  always_comb begin
    case (mem_size_q)
      2'd0:    byte_en = 8'h01;
      2'd1:    byte_en = 8'h03;
      2'd2:    byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    if (state == REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = {result_q[XLEN-1:3], 3'b000};
      mem_req_wen   = (mem_op_q == OP_STORE);
      mem_req_wdata = store_data_q << {result_q[2:0], 3'b000};
      mem_req_wmask = byte_en << result_q[2:0];
    end
  end

  always_comb begin
    resp_shifted = mem_resp_data >> {result_q[2:0], 3'b000};
    case (mem_size_q)
      2'd0:    load_data = unsigned_q ? {{(XLEN-8){1'b0}}, resp_shifted[7:0]}
                                      : {{(XLEN-8){resp_shifted[7]}}, resp_shifted[7:0]};
      2'd1:    load_data = unsigned_q ? {{(XLEN-16){1'b0}}, resp_shifted[15:0]}
                                      : {{(XLEN-16){resp_shifted[15]}}, resp_shifted[15:0]};
      2'd2:    load_data = unsigned_q ? {{(XLEN-32){1'b0}}, resp_shifted[31:0]}
                                      : {{(XLEN-32){resp_shifted[31]}}, resp_shifted[31:0]};
      default: load_data = resp_shifted;
    endcase
  end

  // DONE is entered either straight from IDLE (live inputs) or from RESP (captured fields).
  always_comb begin
    nxt_commit   = 1'b0;
    nxt_wb_valid = 1'b0;
    nxt_except   = 1'b0;
    nxt_code     = '0;
    nxt_rd       = '0;
    nxt_data     = '0;
    nxt_pc       = '0;
    nxt_inst     = '0;
    nxt_periph   = 1'b0;
    if (state_next == DONE) begin
      nxt_commit = 1'b1;
      if (state == IDLE) begin
        nxt_except   = in_misaligned;
        nxt_code     = in_misaligned ? ((in_mem_op == OP_LOAD) ? 6'd4 : 6'd6) : 6'd0;
        nxt_wb_valid = in_rd_wen && (in_rd_addr != 5'd0) && !in_misaligned && (in_mem_op != OP_STORE);
        nxt_rd       = in_rd_addr;
        nxt_data     = in_result;
        nxt_pc       = in_pc;
        nxt_inst     = in_inst;
        nxt_periph   = in_is_mem && (in_result < MEM_BASE);
      end else begin
        nxt_wb_valid = rd_wen_q && (rd_addr_q != 5'd0) && (mem_op_q == OP_LOAD);
        nxt_rd       = rd_addr_q;
        nxt_data     = (mem_op_q == OP_LOAD) ? load_data : result_q;
        nxt_pc       = pc_q;
        nxt_inst     = inst_q;
        nxt_periph   = (result_q < MEM_BASE);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit         <= 1'b0;
      wb_valid       <= 1'b0;
      wb_dest_addr   <= '0;
      wb_dest_data   <= '0;
      except_valid   <= 1'b0;
      except_code    <= '0;
      out_pc         <= '0;
      out_inst       <= '0;
      out_peripheral <= 1'b0;
    end else begin
      commit         <= nxt_commit;
      wb_valid       <= nxt_wb_valid;
      wb_dest_addr   <= nxt_rd;
      wb_dest_data   <= nxt_data;
      except_valid   <= nxt_except;
      except_code    <= nxt_code;
      out_pc         <= nxt_pc;
      out_inst       <= nxt_inst;
      out_peripheral <= nxt_periph;
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((state == REQ) || (state == RESP)) perf_stall_cycles <= perf_stall_cycles + 64'd1;
      if ((state == RESP) && mem_resp_valid) begin
        if (mem_op_q == OP_LOAD) perf_loads  <= perf_loads + 64'd1;
        else                     perf_stores <= perf_stores + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: each transaction's expected bus traffic, latency and
// retire outputs are computed from byte-level arithmetic in a small reference model.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_rd_wen = 1'b0;
  logic [4:0]  in_rd_addr = '0;
  logic [63:0] in_result = '0;
  logic [63:0] in_store_data = '0;
  logic [1:0]  in_mem_op = '0;
  logic [1:0]  in_mem_size = '0;
  logic        in_mem_unsigned = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        wb_valid;
  logic [4:0]  wb_dest_addr;
  logic [63:0] wb_dest_data;
  logic        commit;
  logic        except_valid;
  logic [5:0]  except_code;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_peripheral;

  int vectors_applied = 0;
  int miscompares = 0;

  // Current transaction, filled in by setTx or the random generator.
  logic [63:0] tx_pc, tx_result, tx_sdata, tx_resp;
  logic [31:0] tx_inst;
  logic        tx_rd_wen, tx_uns;
  logic [4:0]  tx_rd;
  logic [1:0]  tx_op, tx_size;
  int          tx_stall, tx_wait_cycles;

  mem_access_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_rd_wen(in_rd_wen), .in_rd_addr(in_rd_addr), .in_result(in_result),
    .in_store_data(in_store_data), .in_mem_op(in_mem_op), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_dest_addr(wb_dest_addr), .wb_dest_data(wb_dest_data),
    .commit(commit), .except_valid(except_valid), .except_code(except_code),
    .out_pc(out_pc), .out_inst(out_inst), .out_peripheral(out_peripheral)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] refLoad(input logic [63:0] data, input logic [63:0] addr,
                                          input int size, input logic uns);
    int          nbytes;
    int          off;
    logic [63:0] mask;
    logic [63:0] raw;
    nbytes = 1 << size;
    off    = int'(addr % 8);
    mask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nbytes * 8)) - 64'd1);
    raw    = (data >> (off * 8)) & mask;
    if (!uns && raw[nbytes * 8 - 1]) raw = raw | ~mask;
    return raw;
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_commit"}, 64'(commit), 64'd0);
    checkOutput({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    checkOutput({tag, "_out_pc"}, out_pc, 64'd0);
  endtask

  task automatic setTx(input logic [63:0] pc, input logic [31:0] inst, input logic rd_wen,
                       input logic [4:0] rd, input logic [63:0] result, input logic [63:0] sdata,
                       input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input int stall, input int wait_cycles, input logic [63:0] resp);
    tx_pc = pc; tx_inst = inst; tx_rd_wen = rd_wen; tx_rd = rd; tx_result = result;
    tx_sdata = sdata; tx_op = op; tx_size = size; tx_uns = uns;
    tx_stall = stall; tx_wait_cycles = wait_cycles; tx_resp = resp;
  endtask

  // Runs one transaction; starts and ends on a falling edge.
  task automatic applyStimulus();
    int          nbytes;
    int          off;
    logic        is_mem, mis, exp_wb;
    logic [15:0] mask16;
    logic [63:0] exp_addr, exp_wdata, exp_data;
    logic [5:0]  exp_code;
    nbytes   = 1 << tx_size;
    off      = int'(tx_result % 8);
    is_mem   = (tx_op == 2'd1) || (tx_op == 2'd2);
    mis      = is_mem && ((tx_result % nbytes) != 0);
    mask16   = ((16'd1 << nbytes) - 16'd1) << off;
    exp_addr = tx_result - 64'(off);
    exp_wdata = tx_sdata << (off * 8);
    exp_code = mis ? ((tx_op == 2'd1) ? 6'd4 : 6'd6) : 6'd0;
    exp_wb   = tx_rd_wen && (tx_rd != 5'd0) && !mis && (tx_op != 2'd2);
    exp_data = (tx_op == 2'd1) ? refLoad(tx_resp, tx_result, int'(tx_size), tx_uns) : tx_result;

    checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_pc = tx_pc; in_inst = tx_inst; in_rd_wen = tx_rd_wen; in_rd_addr = tx_rd;
    in_result = tx_result; in_store_data = tx_sdata; in_mem_op = tx_op; in_mem_size = tx_size;
    in_mem_unsigned = tx_uns;
    mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_data = {$urandom, $urandom};
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; in_pc = '0; in_result = '0; in_mem_op = '0;
    mem_resp_valid = 1'b0;

    if (is_mem && !mis) begin
      for (int s = 0; s <= tx_stall; s++) begin
        checkOutput("req_valid", 64'(mem_req_valid), 64'd1);
        checkOutput("req_addr", mem_req_addr, exp_addr);
        checkOutput("req_wen", 64'(mem_req_wen), 64'(tx_op == 2'd2));
        checkOutput("req_wmask", 64'(mem_req_wmask), 64'(mask16[7:0]));
        if (tx_op == 2'd2) checkOutput("req_wdata", mem_req_wdata, exp_wdata);
        checkOutput("req_no_in_ready", 64'(in_ready), 64'd0);
        checkQuiet("req");
        mem_req_ready  = (s == tx_stall);
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_data  = {$urandom, $urandom};
        @(posedge clock);
        @(negedge clock);
      end
      mem_req_ready = 1'b0;
      for (int w = 0; w <= tx_wait_cycles; w++) begin
        checkOutput("resp_req_low", 64'(mem_req_valid), 64'd0);
        checkQuiet("resp");
        mem_resp_valid = (w == tx_wait_cycles);
        mem_resp_data  = (w == tx_wait_cycles) ? tx_resp : {$urandom, $urandom};
        @(posedge clock);
        @(negedge clock);
      end
      mem_resp_valid = 1'b0;
    end else begin
      checkOutput("no_req", 64'(mem_req_valid), 64'd0);
    end

    checkOutput("commit", 64'(commit), 64'd1);
    checkOutput("except_valid", 64'(except_valid), 64'(mis));
    checkOutput("except_code", 64'(except_code), 64'(exp_code));
    checkOutput("wb_valid", 64'(wb_valid), 64'(exp_wb));
    checkOutput("wb_dest_addr", 64'(wb_dest_addr), 64'(tx_rd));
    if (!mis) checkOutput("wb_dest_data", wb_dest_data, exp_data);
    checkOutput("out_pc", out_pc, tx_pc);
    checkOutput("out_inst", 64'(out_inst), 64'(tx_inst));
    checkOutput("out_peripheral", 64'(out_peripheral), 64'(is_mem && (tx_result < 64'h8000_0000)));
    @(posedge clock);
    @(negedge clock);
    checkQuiet("after_done");
  endtask

  initial begin
    #2;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_except", 64'(except_valid), 64'd0);
    checkOutput("rst_periph", 64'(out_peripheral), 64'd0);
    checkQuiet("rst");
    @(negedge clock);
    reset = 1'b1;

    // ALU op, signed LB, stalled SH, misaligned LW, rd=0 writeback suppression.
    setTx(64'h100, 32'h13, 1'b1, 5'd5, 64'h1234, 64'h0, 2'd0, 2'd0, 1'b0, 0, 0, 64'h0);
    applyStimulus();
    setTx(64'h104, 32'h3, 1'b1, 5'd7, 64'h8000_0003, 64'h0, 2'd1, 2'd0, 1'b0, 0, 1,
          64'h0000_0000_8000_0000);
    applyStimulus();
    setTx(64'h108, 32'h23, 1'b1, 5'd9, 64'h1000_0006, 64'hABCD, 2'd2, 2'd1, 1'b0, 4, 0, 64'h0);
    applyStimulus();
    setTx(64'h10C, 32'h2003, 1'b1, 5'd4, 64'h8000_0002, 64'h0, 2'd1, 2'd2, 1'b0, 0, 0, 64'h0);
    applyStimulus();
    setTx(64'h110, 32'h33, 1'b1, 5'd0, 64'hDEAD, 64'h0, 2'd0, 2'd0, 1'b0, 0, 0, 64'h0);
    applyStimulus();

    for (int n = 0; n < 60; n++) begin
      logic [63:0] addr;
      logic [1:0]  sz;
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom_range(0, 1) ? (64'h8000_0000 + 64'($urandom_range(0, 16'hFFFF)))
                                  : 64'($urandom_range(0, 32'h7FFF_FFFF));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
      setTx({$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            addr, {$urandom, $urandom}, 2'($urandom_range(0, 2)), sz, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
      applyStimulus();
    end

    // Reset while waiting for a response, then a stale response must not retire anything.
    in_valid = 1'b1; in_pc = 64'h200; in_inst = 32'h3003; in_rd_wen = 1'b1; in_rd_addr = 5'd3;
    in_result = 64'h8000_0010; in_mem_op = 2'd1; in_mem_size = 2'd3; mem_req_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    mem_req_ready = 1'b0;
    checkOutput("pre_rst_req_low", 64'(mem_req_valid), 64'd0);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_req_valid", 64'(mem_req_valid), 64'd0);
    checkQuiet("mid_rst");
    @(negedge clock);
    reset = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 64'h1122_3344_5566_7788;
    @(posedge clock);
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checkQuiet("late_resp");
    checkOutput("late_resp_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    checkQuiet("late_resp2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
